uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

Transmit sequencer for the UART. Takes the transmit byte and line configuration from the APB user register block (`tx_data`, `write_flag`, `word_length`, `parity`, `stop_bits`, `set_break`, `baud_rate_cnt`) and serialises it onto `txd` as an asynchronous frame. It has a one-entry holding buffer in front of a shift register, so one byte can be queued while another is on the line. It reports buffer and line status back for the LSR/ISR logic.

## Interface
- No parameters.
- `PCLK` in 1: system clock. All logic is on the rising edge.
- `PRESETn` in 1: reset, synchronous and active-low.
- `tx_data` in 8: transmit byte. Valid in the cycle `write_flag`=1.
- `write_flag` in 1: one-cycle request to load `tx_data` into the holding buffer.
- `word_length` in 2: data bits W. 00=5, 01=6, 10=7, 11=8.
- `parity` in 3: [0] parity enable, [1] even select, [2] stick parity.
- `stop_bits` in 1: 0 = one stop bit, 1 = two stop bits (for all W).
- `set_break` in 1: forces `txd` low while 1.
- `baud_rate_cnt` in 16: B, the number of PCLK cycles per bit. A value of 0 is treated as 1.
- `txd` out 1: serial output, registered.
- `thr_empty` out 1: holding buffer empty.
- `tx_empty` out 1: holding buffer empty and shifter idle.
- `tx_busy` out 1: frame in progress.
- `frame_done` out 1: one-cycle pulse in the last cycle of the last stop bit.
- `overrun` out 1: one-cycle pulse when a write is dropped.

## Operation
- Reset values: `txd`=1, `thr_empty`=1, `tx_empty`=1, `tx_busy`=0, `frame_done`=0, `overrun`=0, state IDLE, all counters 0.
- Holding buffer:
  - A `write_flag` cycle loads `tx_data` and sets `hold_valid`.
  - If `hold_valid`=1 and the buffer is not being consumed that cycle, the write is dropped and `overrun` pulses the next cycle. The old content is kept.
  - If the buffer is consumed in the same cycle as the write, the new byte is accepted. This is not an overrun.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START when `hold_valid`=1. On that transition:
  - Move the byte into the shifter and clear `hold_valid`.
  - Latch W, the parity config, the stop count, and B (with 0 mapped to 1). These stay frozen for the whole frame.
- Each state drives its bit for exactly B cycles. A 16-bit baud counter counts from 0 to B-1; the state advances when the counter reaches B-1.
- START: drives 0, then -> DATA.
- DATA: drives bits LSB first, W bits counted by a 3-bit counter. Then -> PARITY if parity enable=1, else -> STOP.
- PARITY bit value:
  - Let X = XOR of the W data bits only.
  - Even select=1: bit = X. Even select=0: bit = ~X.
  - Stick parity=1 overrides: bit = ~(even select).
- STOP: drives 1 for 1 or 2 bit periods. At the end:
  - If `hold_valid`=1, go straight to START with no idle gap.
  - Otherwise go to IDLE.
- Break: `txd` = frame_bit AND NOT `set_break`. Sequencing, counters and flags keep running during break.
- Status outputs:
  - `tx_busy`=1 in every state except IDLE.
  - `thr_empty` = ~`hold_valid`.
  - `tx_empty` = ~`hold_valid` AND IDLE.
- Configuration changes in mid-frame have no effect until the next frame start.

## Timing
- Cycle numbering, with `write_flag`=1 in cycle N while IDLE:
  - `hold_valid`=1 and `thr_empty`=0 from N+1.
  - The START transition happens at the end of N+1.
  - `txd`=0 and `tx_busy`=1 from N+2.
  - `thr_empty` returns to 1 from N+2.
- Frame length is B*(1+W+P+S) cycles, where P is 0/1 for parity and S is 1/2 stop bits.
- `frame_done` is high in the final cycle of the last stop bit.
- Back-to-back frames: the next start bit begins in the cycle immediately after `frame_done`.
- `overrun` pulses in cycle M+1 for a rejected write in cycle M.
- Reset asserted mid-frame: at the next edge, all outputs take their reset values and the pending byte is discarded.

## Test plan
- 8N1, B=4, write 0x55 -> `txd` = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles, starting at N+2. `frame_done` in cycle N+41. `tx_empty`=1 from N+42.
- 5 bits, odd parity, 2 stop, B=2, write 0x1F -> bits 0,1,1,1,1,1,0,1,1, where the parity bit is 0. Data bits [7:5] are ignored.
- 7 bits, stick parity with even select=1, B=1, write 0x7F -> parity bit 0, frame length 10 cycles.
- Write A, then B during A's data phase, then C while B is held -> `overrun` pulse for C. A and B go out with no gap between A's stop bit and B's start bit. C is never sent.
- `set_break`=1 for 3 cycles mid-data -> `txd`=0 for those cycles. Total frame length and `frame_done` timing are unchanged.
- `PRESETn`=0 for one cycle mid-DATA with a byte held -> next cycle `txd`=1, `tx_empty`=1, no further start bit.

Source files
------------

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: transmit byte, line configuration and status between the register block and the UART transmitter
interface uart_tx_ctrl_if;
  logic [7:0] tx_data;
  logic write_flag;
  logic [1:0] word_length;
  logic [2:0] parity;
  logic stop_bits;
  logic set_break;
  logic [15:0] baud_rate_cnt;
  logic txd;
  logic thr_empty;
  logic tx_empty;
  logic tx_busy;
  logic frame_done;
  logic overrun;
  modport master (
    output tx_data, write_flag, word_length, parity, stop_bits, set_break, baud_rate_cnt,
    input txd, thr_empty, tx_empty, tx_busy, frame_done, overrun
  );
  modport slave (
    input tx_data, write_flag, word_length, parity, stop_bits, set_break, baud_rate_cnt,
    output txd, thr_empty, tx_empty, tx_busy, frame_done, overrun
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: one-entry holding buffer feeding a frame shifter that serialises start/data/parity/stop onto txd
module uart_tx_ctrl (
  input logic PCLK,
  input logic PRESETn,
  uart_tx_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic hold_valid, hold_valid_n;
  logic [7:0] hold_data, hold_data_n, sh, sh_n, mask;
  logic [1:0] w_q, w_n;
  logic [2:0] par_q, par_n, bit_cnt, bit_n;
  logic stop_q, stop_n, stop_cnt, stop_cnt_n;
  logic [15:0] b_q, b_n, cnt, cnt_n;
  logic pb, pb_n, txd_q, txd_n, ovr_q, ovr_n;
  logic done, last_stop, load, accept;
  always_comb begin
    done = cnt == b_q - 16'd1;
    last_stop = state == STOP && done && stop_cnt == stop_q;
    load = hold_valid && (state == IDLE || last_stop);
    accept = bus.write_flag && (!hold_valid || load);
    mask = 8'hFF >> (2'd3 - bus.word_length);
    hold_valid_n = accept || (hold_valid && !load);
    hold_data_n = accept ? bus.tx_data : hold_data;
    ovr_n = bus.write_flag && hold_valid && !load;
    state_n = state;
    sh_n = sh;
    w_n = w_q;
    par_n = par_q;
    stop_n = stop_q;
    b_n = b_q;
    pb_n = pb;
    bit_n = bit_cnt;
    stop_cnt_n = stop_cnt;
    cnt_n = (state == IDLE || done) ? 16'd0 : cnt + 16'd1;
    // Line configuration is captured here so mid-frame register writes wait for the next frame
    if (load) begin
      state_n = START;
      sh_n = hold_data;
      w_n = bus.word_length;
      par_n = bus.parity;
      stop_n = bus.stop_bits;
      b_n = bus.baud_rate_cnt == 16'd0 ? 16'd1 : bus.baud_rate_cnt;
      pb_n = bus.parity[2] ? ~bus.parity[1] : ~(^(hold_data & mask) ^ bus.parity[1]);
      cnt_n = 16'd0;
      bit_n = 3'd0;
      stop_cnt_n = 1'b0;
    end else if (done) begin
      case (state)
        START: state_n = DATA;
        DATA: begin
          if (bit_cnt == {1'b1, w_q}) state_n = par_q[0] ? PARITY : STOP;
          else begin
            bit_n = bit_cnt + 3'd1;
            sh_n = sh >> 1;
          end
        end
        PARITY: state_n = STOP;
        STOP: begin
          if (stop_cnt == stop_q) state_n = IDLE;
          else stop_cnt_n = 1'b1;
        end
        default: ;
      endcase
    end
    txd_n = (state_n == DATA ? sh_n[0] : state_n == PARITY ? pb_n : state_n != START) & ~bus.set_break;
  end
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state <= IDLE;
      hold_valid <= 1'b0;
      hold_data <= '0;
      sh <= '0;
      w_q <= '0;
      par_q <= '0;
      stop_q <= 1'b0;
      b_q <= '0;
      cnt <= '0;
      bit_cnt <= '0;
      stop_cnt <= 1'b0;
      pb <= 1'b0;
      txd_q <= 1'b1;
      ovr_q <= 1'b0;
    end else begin
      state <= state_n;
      hold_valid <= hold_valid_n;
      hold_data <= hold_data_n;
      sh <= sh_n;
      w_q <= w_n;
      par_q <= par_n;
      stop_q <= stop_n;
      b_q <= b_n;
      cnt <= cnt_n;
      bit_cnt <= bit_n;
      stop_cnt <= stop_cnt_n;
      pb <= pb_n;
      txd_q <= txd_n;
      ovr_q <= ovr_n;
    end
  end
  assign bus.txd = txd_q;
  assign bus.thr_empty = ~hold_valid;
  assign bus.tx_empty = ~hold_valid && state == IDLE;
  assign bus.tx_busy = state != IDLE;
  assign bus.frame_done = last_stop;
  assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed frame checks; capture index i is the cycle N+1+i after a write in cycle N
module tb_uart_tx_ctrl;
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  uart_tx_ctrl_if bus();
  uart_tx_ctrl dut (.PCLK(PCLK), .PRESETn(PRESETn), .bus(bus));
  always #5 PCLK = ~PCLK;
  int tests = 0;
  int fails = 0;
  logic [127:0] cap_txd, cap_fd, cap_te, cap_thr, cap_ov, exp_v, exp_fd;
  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask
  function automatic logic [127:0] frame(input logic [15:0] bits, input int nb, input int b, input int lead);
    logic [127:0] v;
    v = '1;
    for (int k = 0; k < nb; k++)
      for (int j = 0; j < b; j++) v[lead + k * b + j] = bits[k];
    return v;
  endfunction
  task automatic line_cfg(input logic [1:0] wl, input logic [2:0] par, input logic sb, input logic [15:0] b);
    bus.word_length = wl;
    bus.parity = par;
    bus.stop_bits = sb;
    bus.baud_rate_cnt = b;
  endtask
  task automatic send(input logic [7:0] d);
    bus.tx_data = d;
    bus.write_flag = 1'b1;
    tick();
    bus.write_flag = 1'b0;
  endtask
  task automatic run(input int n, input int wa, input logic [7:0] da, input int wb, input logic [7:0] db, input int bs, input int be);
    cap_txd = '0; cap_fd = '0; cap_te = '0; cap_thr = '0; cap_ov = '0;
    for (int i = 0; i < n; i++) begin
      bus.write_flag = (i == wa) || (i == wb);
      bus.tx_data = (i == wb) ? db : da;
      bus.set_break = (i >= bs) && (i < be);
      cap_txd[i] = bus.txd;
      cap_fd[i] = bus.frame_done;
      cap_te[i] = bus.tx_empty;
      cap_thr[i] = bus.thr_empty;
      cap_ov[i] = bus.overrun;
      tick();
    end
    bus.write_flag = 1'b0;
    bus.set_break = 1'b0;
  endtask
  task automatic test_reset;
    PRESETn = 1'b0;
    tick();
    tick();
    tests += 6;
    if (bus.txd !== 1'b1) begin fails++; $display("FAIL reset_txd got %b want 1", bus.txd); end
    if (bus.thr_empty !== 1'b1) begin fails++; $display("FAIL reset_thr_empty got %b want 1", bus.thr_empty); end
    if (bus.tx_empty !== 1'b1) begin fails++; $display("FAIL reset_tx_empty got %b want 1", bus.tx_empty); end
    if (bus.tx_busy !== 1'b0) begin fails++; $display("FAIL reset_tx_busy got %b want 0", bus.tx_busy); end
    if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done); end
    if (bus.overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
    PRESETn = 1'b1;
    tick();
  endtask
  task automatic test_8n1;
    line_cfg(2'b11, 3'b000, 1'b0, 16'd4);
    send(8'h55);
    tests += 2;
    if (bus.thr_empty !== 1'b0) begin fails++; $display("FAIL 8n1_thr_full got %b want 0", bus.thr_empty); end
    if (bus.tx_busy !== 1'b0) begin fails++; $display("FAIL 8n1_busy_n1 got %b want 0", bus.tx_busy); end
    run(44, -1, 8'h00, -1, 8'h00, -1, -1);
    exp_v = frame(16'h02AA, 10, 4, 1);
    exp_fd = 128'd1 << 40;
    tests += 4;
    if (cap_txd[43:0] !== exp_v[43:0]) begin fails++; $display("FAIL 8n1_txd got %h want %h", cap_txd[43:0], exp_v[43:0]); end
    if (cap_fd[43:0] !== exp_fd[43:0]) begin fails++; $display("FAIL 8n1_frame_done got %h want %h", cap_fd[43:0], exp_fd[43:0]); end
    if (cap_te[41:40] !== 2'b10) begin fails++; $display("FAIL 8n1_tx_empty got %b want 10", cap_te[41:40]); end
    if (cap_thr[1] !== 1'b1) begin fails++; $display("FAIL 8n1_thr_empty_n2 got %b want 1", cap_thr[1]); end
  endtask
  task automatic test_parity;
    line_cfg(2'b00, 3'b001, 1'b1, 16'd2);
    send(8'h1F);
    run(22, -1, 8'h00, -1, 8'h00, -1, -1);
    exp_v = frame(16'h01BE, 9, 2, 1);
    exp_fd = 128'd1 << 18;
    tests += 2;
    if (cap_txd[21:0] !== exp_v[21:0]) begin fails++; $display("FAIL odd5_1f_txd got %h want %h", cap_txd[21:0], exp_v[21:0]); end
    if (cap_fd[21:0] !== exp_fd[21:0]) begin fails++; $display("FAIL odd5_1f_frame_done got %h want %h", cap_fd[21:0], exp_fd[21:0]); end
    send(8'hF0);
    run(22, -1, 8'h00, -1, 8'h00, -1, -1);
    exp_v = frame(16'h01A0, 9, 2, 1);
    tests += 1;
    if (cap_txd[21:0] !== exp_v[21:0]) begin fails++; $display("FAIL odd5_f0_txd got %h want %h", cap_txd[21:0], exp_v[21:0]); end
  endtask
  task automatic test_stick_and_b0;
    line_cfg(2'b10, 3'b111, 1'b0, 16'd1);
    send(8'h7F);
    run(14, -1, 8'h00, -1, 8'h00, -1, -1);
    exp_v = frame(16'h02FE, 10, 1, 1);
    exp_fd = 128'd1 << 10;
    tests += 3;
    if (cap_txd[13:0] !== exp_v[13:0]) begin fails++; $display("FAIL stick7_txd got %h want %h", cap_txd[13:0], exp_v[13:0]); end
    if (cap_fd[13:0] !== exp_fd[13:0]) begin fails++; $display("FAIL stick7_frame_done got %h want %h", cap_fd[13:0], exp_fd[13:0]); end
    if (cap_te[11] !== 1'b1) begin fails++; $display("FAIL stick7_tx_empty got %b want 1", cap_te[11]); end
    line_cfg(2'b11, 3'b000, 1'b0, 16'd0);
    send(8'hA5);
    run(14, -1, 8'h00, -1, 8'h00, -1, -1);
    exp_v = frame(16'h034A, 10, 1, 1);
    tests += 2;
    if (cap_txd[13:0] !== exp_v[13:0]) begin fails++; $display("FAIL b0_txd got %h want %h", cap_txd[13:0], exp_v[13:0]); end
    if (cap_fd[13:0] !== exp_fd[13:0]) begin fails++; $display("FAIL b0_frame_done got %h want %h", cap_fd[13:0], exp_fd[13:0]); end
  endtask
  task automatic test_back_to_back;
    line_cfg(2'b11, 3'b000, 1'b0, 16'd2);
    send(8'h0F);
    run(60, 5, 8'h33, 7, 8'h00, -1, -1);
    exp_v = frame(16'h021E, 10, 2, 1) & frame(16'h0266, 10, 2, 21);
    exp_fd = (128'd1 << 20) | (128'd1 << 40);
    tests += 6;
    if (cap_txd[59:0] !== exp_v[59:0]) begin fails++; $display("FAIL b2b_txd got %h want %h", cap_txd[59:0], exp_v[59:0]); end
    if (cap_fd[59:0] !== exp_fd[59:0]) begin fails++; $display("FAIL b2b_frame_done got %h want %h", cap_fd[59:0], exp_fd[59:0]); end
    if (cap_ov[59:0] !== 60'd1 << 8) begin fails++; $display("FAIL b2b_overrun got %h want %h", cap_ov[59:0], 60'd1 << 8); end
    if (cap_thr[6] !== 1'b0) begin fails++; $display("FAIL b2b_thr_held got %b want 0", cap_thr[6]); end
    if (cap_thr[21] !== 1'b1) begin fails++; $display("FAIL b2b_thr_freed got %b want 1", cap_thr[21]); end
    if (cap_te[41] !== 1'b1) begin fails++; $display("FAIL b2b_tx_empty got %b want 1", cap_te[41]); end
  endtask
  task automatic test_write_on_consume;
    line_cfg(2'b11, 3'b000, 1'b0, 16'd1);
    send(8'h00);
    run(30, 0, 8'hFF, -1, 8'h00, -1, -1);
    exp_v = frame(16'h0200, 10, 1, 1) & frame(16'h03FE, 10, 1, 11);
    exp_fd = (128'd1 << 10) | (128'd1 << 20);
    tests += 3;
    if (cap_txd[29:0] !== exp_v[29:0]) begin fails++; $display("FAIL consume_txd got %h want %h", cap_txd[29:0], exp_v[29:0]); end
    if (cap_fd[29:0] !== exp_fd[29:0]) begin fails++; $display("FAIL consume_frame_done got %h want %h", cap_fd[29:0], exp_fd[29:0]); end
    if (cap_ov[29:0] !== 30'd0) begin fails++; $display("FAIL consume_overrun got %h want 0", cap_ov[29:0]); end
  endtask
  task automatic test_break;
    int zeros, first;
    line_cfg(2'b11, 3'b000, 1'b0, 16'd4);
    send(8'hFF);
    run(48, -1, 8'h00, -1, 8'h00, 10, 13);
    zeros = 0;
    first = -1;
    for (int i = 5; i <= 36; i++)
      if (cap_txd[i] === 1'b0) begin
        zeros++;
        if (first < 0) first = i;
      end
    exp_fd = 128'd1 << 40;
    tests += 5;
    if (zeros != 3) begin fails++; $display("FAIL break_zero_count got %0d want 3", zeros); end
    if (first != 10 && first != 11) begin fails++; $display("FAIL break_first_low got %0d want 10 or 11", first); end
    if (cap_txd[4:1] !== 4'h0) begin fails++; $display("FAIL break_start got %b want 0000", cap_txd[4:1]); end
    if (cap_txd[40:37] !== 4'hF) begin fails++; $display("FAIL break_stop got %b want 1111", cap_txd[40:37]); end
    if (cap_fd[47:0] !== exp_fd[47:0]) begin fails++; $display("FAIL break_frame_done got %h want %h", cap_fd[47:0], exp_fd[47:0]); end
  endtask
  task automatic test_reset_mid_frame;
    line_cfg(2'b11, 3'b000, 1'b0, 16'd4);
    send(8'h00);
    run(10, 1, 8'h12, -1, 8'h00, -1, -1);
    tests += 2;
    if (bus.txd !== 1'b0) begin fails++; $display("FAIL rst_mid_pre_txd got %b want 0", bus.txd); end
    if (bus.thr_empty !== 1'b0) begin fails++; $display("FAIL rst_mid_pre_thr got %b want 0", bus.thr_empty); end
    PRESETn = 1'b0;
    tick();
    PRESETn = 1'b1;
    tests += 4;
    if (bus.txd !== 1'b1) begin fails++; $display("FAIL rst_mid_txd got %b want 1", bus.txd); end
    if (bus.tx_empty !== 1'b1) begin fails++; $display("FAIL rst_mid_tx_empty got %b want 1", bus.tx_empty); end
    if (bus.thr_empty !== 1'b1) begin fails++; $display("FAIL rst_mid_thr_empty got %b want 1", bus.thr_empty); end
    if (bus.tx_busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b want 0", bus.tx_busy); end
    run(50, -1, 8'h00, -1, 8'h00, -1, -1);
    tests += 2;
    if (cap_txd[49:0] !== {50{1'b1}}) begin fails++; $display("FAIL rst_mid_idle_txd got %h want all ones", cap_txd[49:0]); end
    if (cap_fd[49:0] !== 50'd0) begin fails++; $display("FAIL rst_mid_frame_done got %h want 0", cap_fd[49:0]); end
  endtask
  initial begin
    bus.tx_data = 8'h00;
    bus.write_flag = 1'b0;
    bus.set_break = 1'b0;
    line_cfg(2'b11, 3'b000, 1'b0, 16'd4);
    test_reset();
    test_8n1();
    test_parity();
    test_stick_and_b0();
    test_back_to_back();
    test_write_on_consume();
    test_break();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
